// File: rtl/alu_sequencer.sv
// Instruction issuer for the 8-bit combinational ALU: 4-entry register file, flag register,
// IDLE/EXEC/DONE sequencing. Optional carry chaining via `define ALU_SEQ_CARRY_CHAIN_EN.
module alu_sequencer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_valid_i,
  output logic                 instr_ready_o,
  input  logic [3:0]           instr_op_i,
  input  logic [1:0]           instr_rd_i,
  input  logic [1:0]           instr_rs_i,
  input  logic [BUS_WIDTH-1:0] instr_imm_i,
  output logic [BUS_WIDTH-1:0] alu_a_o,
  output logic [BUS_WIDTH-1:0] alu_b_o,
  output logic [3:0]           alu_opcode_o,
  output logic                 alu_car_in_o,
  input  logic [BUS_WIDTH-1:0] alu_y_i,
  input  logic                 alu_car_out_i,
  input  logic                 alu_borrow_i,
  input  logic                 alu_zero_i,
  input  logic                 alu_parity_i,
  input  logic                 alu_invalid_op_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [BUS_WIDTH-1:0] res_data_o,
  output logic [3:0]           res_flags_o,
  output logic                 res_err_o,
  output logic                 err_sticky_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_LOAD    = 4'd0;
  localparam logic [3:0] OP_LAST_OK = 4'd9;
  localparam int         FLAG_C     = 3;
  localparam int         FLAG_B     = 2;

  function automatic logic parity_f(input logic [BUS_WIDTH-1:0] v);
    return ^v;
  endfunction

  state_e               state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [1:0]           rd_q, rd_d;
  logic [1:0]           rs_q, rs_d;
  logic [BUS_WIDTH-1:0] imm_q, imm_d;
  logic [BUS_WIDTH-1:0] rf_q [4];
  logic [BUS_WIDTH-1:0] rf_d [4];
  logic [3:0]           flags_q, flags_d;
  logic                 err_sticky_q, err_sticky_d;
  logic                 res_valid_q, res_valid_d;
  logic [BUS_WIDTH-1:0] res_data_q, res_data_d;
  logic [3:0]           res_flags_q, res_flags_d;
  logic                 res_err_q, res_err_d;
  logic                 carry_in_s;
  logic                 accept_s;
  logic                 exec_err_s;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign carry_in_s = flags_q[FLAG_C];
`else
  assign carry_in_s = 1'b0;
`endif

  assign instr_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign accept_s      = instr_ready_o && instr_valid_i;
  // Opcodes above 9 are rejected even if the ALU fails to flag them.
  assign exec_err_s    = alu_invalid_op_i || (op_q > OP_LAST_OK);

  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_flags_o  = res_flags_q;
  assign res_err_o    = res_err_q;
  assign err_sticky_o = err_sticky_q;

  // State, register file, flags and result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'd0;
      rd_q         <= 2'd0;
      rs_q         <= 2'd0;
      imm_q        <= '0;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= '0;
      end
      flags_q      <= 4'd0;
      err_sticky_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_flags_q  <= 4'd0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rd_q         <= rd_d;
      rs_q         <= rs_d;
      imm_q        <= imm_d;
      rf_q         <= rf_d;
      flags_q      <= flags_d;
      err_sticky_q <= err_sticky_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_flags_q  <= res_flags_d;
      res_err_q    <= res_err_d;
    end
  end

  // Next-state, ALU drive and capture of ALU results at the end of EXEC.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    rd_d         = rd_q;
    rs_d         = rs_q;
    imm_d        = imm_q;
    rf_d         = rf_q;
    flags_d      = flags_q;
    err_sticky_d = err_sticky_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_flags_d  = res_flags_q;
    res_err_d    = res_err_q;
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_opcode_o = 4'd0;
    alu_car_in_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          op_d    = instr_op_i;
          rd_d    = instr_rd_i;
          rs_d    = instr_rs_i;
          imm_d   = instr_imm_i;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        alu_a_o      = rf_q[rd_q];
        alu_b_o      = rf_q[rs_q];
        alu_opcode_o = op_q;
        alu_car_in_o = carry_in_s;
        state_d      = ST_DONE;
        res_valid_d  = 1'b1;
        if (op_q == OP_LOAD) begin
          rf_d[rd_q] = imm_q;
          flags_d    = {flags_q[FLAG_C], flags_q[FLAG_B], (imm_q == '0), parity_f(imm_q)};
          res_data_d = imm_q;
          res_err_d  = 1'b0;
        end else if (exec_err_s) begin
          res_data_d   = rf_q[rd_q];
          res_err_d    = 1'b1;
          err_sticky_d = 1'b1;
        end else begin
          rf_d[rd_q] = alu_y_i;
          flags_d    = {alu_car_out_i, alu_borrow_i, alu_zero_i, alu_parity_i};
          res_data_d = alu_y_i;
          res_err_d  = 1'b0;
        end
        res_flags_d = flags_d;
      end

      ST_DONE: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU stub, scoreboard model of registers/flags,
// directed scenarios followed by randomized instructions.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_op;
  logic [1:0] instr_rd, instr_rs;
  logic [7:0] instr_imm;
  logic [7:0] alu_a, alu_b, alu_y;
  logic [3:0] alu_opcode;
  logic       alu_car_in, alu_car_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
  logic       res_valid, res_ready, res_err, err_sticky;
  logic [7:0] res_data;
  logic [3:0] res_flags;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_rf [4];
  logic [3:0] m_flags;
  logic       m_sticky;
  logic [7:0] last_data;
  logic [3:0] last_flags;
  logic       last_err;

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       b;
    logic       inv;
  } alu_res_t;

  always #5 clk = ~clk;

  alu_sequencer #(.BUS_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
    .instr_op_i(instr_op), .instr_rd_i(instr_rd), .instr_rs_i(instr_rs), .instr_imm_i(instr_imm),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_opcode_o(alu_opcode), .alu_car_in_o(alu_car_in),
    .alu_y_i(alu_y), .alu_car_out_i(alu_car_out), .alu_borrow_i(alu_borrow),
    .alu_zero_i(alu_zero), .alu_parity_i(alu_parity), .alu_invalid_op_i(alu_invalid_op),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_flags_o(res_flags), .res_err_o(res_err), .err_sticky_o(err_sticky)
  );

  // Behaviour of the attached ALU, written with plain integer arithmetic.
  function automatic alu_res_t ref_alu(input logic [3:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic cin);
    alu_res_t r;
    int unsigned ia, ib, s;
    ia = a;
    ib = b;
    r = '0;
    case (op)
      4'd1: begin s = ia + ib;       r.y = 8'(s % 256); r.c = (s > 255); end
      4'd2: begin s = ia + ib + cin; r.y = 8'(s % 256); r.c = (s > 255); end
      4'd3: begin s = (ia + 256 - ib) % 256; r.y = 8'(s); r.b = (ia < ib); end
      4'd4: begin s = ia + 1;        r.y = 8'(s % 256); r.c = (s > 255); end
      4'd5: begin s = (ia + 255) % 256; r.y = 8'(s); r.b = (ia == 0); end
      4'd6: r.y = a & b;
      4'd7: r.y = 8'(255 - ia);
      4'd8: r.y = 8'(((ia * 2) % 256) + (ia / 128));
      4'd9: r.y = 8'((ia / 2) + ((ia % 2) * 128));
      4'd0: r.y = 8'd0;
      default: r.inv = 1'b1;
    endcase
    return r;
  endfunction

  alu_res_t stub_s;
  always_comb begin
    stub_s         = ref_alu(alu_opcode, alu_a, alu_b, alu_car_in);
    alu_y          = stub_s.y;
    alu_car_out    = stub_s.c;
    alu_borrow     = stub_s.b;
    alu_invalid_op = stub_s.inv;
    alu_zero       = (stub_s.y == 8'd0);
    alu_parity     = ($countones(stub_s.y) % 2) == 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'd0;
    m_flags  = 4'd0;
    m_sticky = 1'b0;
  endtask

  // Issue one instruction, check the EXEC drive and the result beat against the model.
  task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm, input int hold);
    alu_res_t   r;
    logic       cin;
    logic [7:0] e_data;
    logic [3:0] e_flags;
    logic       e_err;
    int         cnt;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    instr_imm   = imm;
    res_ready   = 1'b0;
    cnt = 0;
    while (!instr_ready && cnt < 20) begin
      tick();
      cnt++;
    end
    check("instr_ready_before_accept", 32'(instr_ready), 32'd1);
    tick();
    instr_valid = 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    cin = m_flags[3];
`else
    cin = 1'b0;
`endif
    check("exec_opcode", 32'(alu_opcode), 32'(op));
    check("exec_alu_a", 32'(alu_a), 32'(m_rf[rd]));
    check("exec_alu_b", 32'(alu_b), 32'(m_rf[rs]));
    check("exec_car_in", 32'(alu_car_in), 32'(cin));
    check("exec_res_valid_low", 32'(res_valid), 32'd0);
    check("exec_ready_low", 32'(instr_ready), 32'd0);

    r = ref_alu(op, m_rf[rd], m_rf[rs], cin);
    if (op == 4'd0) begin
      m_rf[rd] = imm;
      m_flags  = {m_flags[3], m_flags[2], imm == 8'd0, ($countones(imm) % 2) == 1};
      e_data   = imm;
      e_err    = 1'b0;
    end else if (op > 4'd9) begin
      e_data   = m_rf[rd];
      e_err    = 1'b1;
      m_sticky = 1'b1;
    end else begin
      m_rf[rd] = r.y;
      m_flags  = {r.c, r.b, r.y == 8'd0, ($countones(r.y) % 2) == 1};
      e_data   = r.y;
      e_err    = 1'b0;
    end
    e_flags = m_flags;

    tick();
    check("res_valid", 32'(res_valid), 32'd1);
    check("res_data", 32'(res_data), 32'(e_data));
    check("res_flags", 32'(res_flags), 32'(e_flags));
    check("res_err", 32'(res_err), 32'(e_err));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_res_valid", 32'(res_valid), 32'd1);
      check("hold_ready_low", 32'(instr_ready), 32'd0);
      check("hold_res_data", 32'(res_data), 32'(e_data));
    end
    last_data  = res_data;
    last_flags = res_flags;
    last_err   = res_err;
    res_ready  = 1'b1;
    tick();
    res_ready = 1'b0;
    check("res_valid_drop", 32'(res_valid), 32'd0);
    check("ready_after_done", 32'(instr_ready), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr_op    = 4'd0;
    instr_rd    = 2'd0;
    instr_rs    = 2'd0;
    instr_imm   = 8'd0;
    res_ready   = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_instr_ready", 32'(instr_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_flags", 32'(res_flags), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
    check("rst_alu_car_in", 32'(alu_car_in), 32'd0);
    rst = 1'b0;
    tick();

    issue(4'd0, 2'd0, 2'd0, 8'hF0, 0);
    issue(4'd0, 2'd1, 2'd0, 8'h20, 0);
    issue(4'd1, 2'd0, 2'd1, 8'h00, 0);
    check("plan_add_data", 32'(last_data), 32'h10);
    check("plan_add_flags", 32'(last_flags), 32'b1001);
    issue(4'd2, 2'd0, 2'd1, 8'h00, 0);
`ifdef ALU_SEQ_CARRY_CHAIN_EN
    check("plan_adc_data", 32'(last_data), 32'h31);
`else
    check("plan_adc_data", 32'(last_data), 32'h30);
`endif
    issue(4'd0, 2'd2, 2'd0, 8'h00, 0);
    issue(4'd5, 2'd2, 2'd3, 8'h00, 1);
    check("plan_dec_data", 32'(last_data), 32'hFF);
    check("plan_dec_flags", 32'(last_flags), 32'b0100);
    issue(4'd3, 2'd2, 2'd2, 8'h00, 0);
    check("plan_sub_data", 32'(last_data), 32'h00);
    check("plan_sub_flags", 32'(last_flags), 32'b0010);
    issue(4'd0, 2'd3, 2'd0, 8'h81, 0);
    issue(4'd8, 2'd3, 2'd0, 8'h00, 0);
    check("plan_rol", 32'(last_data), 32'h03);
    issue(4'd9, 2'd3, 2'd1, 8'h00, 0);
    check("plan_ror", 32'(last_data), 32'h81);
    issue(4'd0, 2'd3, 2'd0, 8'h0F, 0);
    issue(4'd7, 2'd3, 2'd2, 8'h00, 0);
    check("plan_not", 32'(last_data), 32'hF0);
    issue(4'd1, 2'd1, 2'd1, 8'h00, 0);
    check("plan_double", 32'(last_data), 32'h40);
    issue(4'd12, 2'd3, 2'd0, 8'h00, 5);
    check("plan_err", 32'(last_err), 32'd1);
    check("plan_err_data", 32'(last_data), 32'hF0);

    // Reset while an add is in EXEC.
    instr_valid = 1'b1;
    instr_op    = 4'd1;
    instr_rd    = 2'd0;
    instr_rs    = 2'd1;
    tick();
    instr_valid = 1'b0;
    check("mid_exec_opcode", 32'(alu_opcode), 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_ready", 32'(instr_ready), 32'd0);
    check("mid_rst_sticky", 32'(err_sticky), 32'd0);
    rst = 1'b0;
    model_reset();
    tick();
    check("post_rst_ready", 32'(instr_ready), 32'd1);
    check("post_rst_res_valid", 32'(res_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      issue(4'd6, 2'(i), 2'(i), 8'h00, 0);
      check("post_rst_reg_zero", 32'(last_data), 32'd0);
    end

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      int unsigned sel;
      logic [3:0]  op;
      sel = $urandom_range(0, 21);
      op  = (sel < 16) ? 4'(sel) : 4'd0;
      issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequential instruction issuer that drives the team's combinational 8-bit ALU and consumes its result and flags: the initiator side of the ALU's opcode/operand interface.

- Accepts instructions over a valid/ready handshake.
- Reads operands from a 4-entry register file and presents them to the ALU.
- Writes the ALU result back to the register file and updates a flag register.
- Returns each result over a valid/ready result channel.
- Sits between a host or test driver and one ALU instance.

## Interface
- bus_width, 8, datapath width; must match the attached ALU.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept.
- instr_op  in  4  opcode:
  - 0 = LOAD immediate.
  - 1..9 = ALU ops: add, add-with-carry, sub, inc, dec, and, not, rol, ror.
  - 10..15 = invalid.
- instr_rd  in  2  destination register, also operand A.
- instr_rs  in  2  source register, operand B.
- instr_imm  in  bus_width  immediate for LOAD.
- alu_a, alu_b  out  bus_width  ALU operands.
- alu_opcode  out  4  ALU opcode.
- alu_car_in  out  1  ALU carry in.
- alu_y  in  bus_width  ALU result.
- alu_car_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op  in  1 each  ALU flags.
- res_valid  out  1  result beat valid.
- res_ready  in  1  consumer accepts result.
- res_data  out  bus_width  value written to rd; unchanged rd value on error.
- res_flags  out  4  {C, B, Z, P} after the instruction.
- res_err  out  1  this instruction was invalid.
- err_sticky  out  1  any invalid instruction since reset.

## Operation
- State: R0..R3 (bus_width each), flag register {C, B, Z, P}, FSM.
- FSM states and transitions:
  - IDLE: instr_ready=1. On instr_valid, latch op/rd/rs/imm and go to EXEC.
  - EXEC, one cycle:
    - alu_a=R[rd], alu_b=R[rs], alu_opcode=op, alu_car_in=C (see Configuration).
    - On the exiting edge, capture the ALU outputs as below, then go to DONE.
  - DONE: res_valid=1 with res_data/res_flags/res_err stable. On res_ready go to IDLE.
- Capture rules at the end of EXEC:
  - op 1..9 and alu_invalid_op=0:
    - R[rd] <= alu_y.
    - C <= alu_car_out, B <= alu_borrow, Z <= alu_zero, P <= alu_parity.
  - op 0 (LOAD):
    - ALU outputs ignored.
    - R[rd] <= imm, Z <= (imm==0), P <= ^imm.
    - C and B unchanged.
  - alu_invalid_op=1 (op 0 excluded): no register or flag write; res_err=1; err_sticky <= 1.
- Unary ops (4, 5, 7, 8, 9) ignore rs; alu_b is still driven from R[rs].
- rd==rs is legal. B is read pre-write, e.g. add R1,R1 doubles R1.
- Outside EXEC: alu_opcode=0, alu_a=alu_b=0, alu_car_in=0.
- All arithmetic is modulo 2^bus_width; no wider internal result.

## Timing
- Reset values, all applied on the first clk edge with rst=1:
  - state IDLE.
  - R0..R3 = 0, flags = 0, err_sticky = 0.
  - res_valid = 0, res_data = 0, res_flags = 0, res_err = 0.
  - ALU outputs as outside EXEC.
  - instr_ready = 0 while rst is high.
- Latency: accept at edge N; EXEC during cycle N+1; res_valid high from cycle N+2.
- Throughput: at most one instruction per 3 cycles with res_ready tied 1.
- instr_ready is low in EXEC and DONE. An instr_valid held during those states is not accepted and must be held by the source.
- res_* outputs hold until the res_ready handshake; res_valid drops the cycle after acceptance.
- rst mid-EXEC or mid-DONE: the in-flight instruction is discarded with no write and no result beat.

## Configuration
- ALU_SEQ_CARRY_CHAIN_EN defined:
  - alu_car_in = C flag in EXEC.
  - Op 2 chains carry across instructions.
- ALU_SEQ_CARRY_CHAIN_EN undefined:
  - alu_car_in tied 0, so op 2 yields the same result as op 1.
  - C is still captured and reported.

## Test plan
- LOAD R0=0xF0, LOAD R1=0x20, add R0,R1 -> res_data=0x10, res_flags C=1 B=0 Z=0 P=1; result beat 2 cycles after accept.
- Then add-with-carry R0,R1 -> with macro res_data=0x31, without macro res_data=0x30.
- LOAD R2=0x00, dec R2 -> res_data=0xFF, B=1, Z=0, P=0; then sub R2,R2 -> 0x00, B=0, Z=1.
- LOAD R3=0x81: rol R3 -> 0x03, then ror R3 -> 0x81. LOAD R3=0x0F: not R3 -> 0xF0.
- Issue op 12 -> res_err=1, err_sticky=1, flags and registers unchanged. Hold res_ready=0 for 5 cycles -> res_valid stays high, instr_ready stays 0.
- Assert rst during EXEC of add -> no result beat, all registers read 0 afterward, instr_ready=1 the cycle after rst falls.
